// File: rtl/pc_fetch_ctrl.sv
// Fetch/sequence controller for the calculator PC unit: fetches instruction
// bytes over a req/ack handshake, decodes the class and strobes the PC update.
module pc_fetch_ctrl #(
    parameter int         TIMEOUT = 15,
    parameter int         CNT_W   = 16,
    parameter logic [7:0] HALT_OP = 8'hFF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [7:0]       pc_in,
    input  logic [7:0]       alu_res,
    input  logic             alu_zero,
    output logic [7:0]       mem_addr,
    output logic             mem_req,
    input  logic             mem_ack,
    input  logic [7:0]       mem_rdata,
    output logic [1:0]       pc_m,
    output logic [7:0]       pc_data,
    output logic             pc_step,
    output logic [7:0]       instr,
    output logic             instr_valid,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_UPDATE,
        S_SETTLE,
        S_HALT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [7:0]       instr_q, instr_d;
    logic             instr_valid_q, instr_valid_d;
    logic [1:0]       pc_m_q, pc_m_d;
    logic [7:0]       pc_data_q, pc_data_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;

    logic             taken;
    logic [7:0]       pc_plus1;
    logic [7:0]       pc_plus2;

    // The PC unit reads the ALU result itself when pc_m=11.
    logic             unused_ok;
    assign unused_ok = ^alu_res;

    assign taken    = !instr_q[5] || alu_zero;
    assign pc_plus1 = pc_in + 8'd1;
    assign pc_plus2 = pc_in + 8'd2;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_m_q        <= 2'b00;
            pc_data_q     <= '0;
            retired_q     <= '0;
            halted_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_m_q        <= pc_m_d;
            pc_data_q     <= pc_data_d;
            retired_q     <= retired_d;
            halted_q      <= halted_d;
            err_q         <= err_d;
        end
    end

    // pc_m/pc_data are computed on the way into UPDATE so they are stable during the strobe.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        pc_m_d        = pc_m_q;
        pc_data_d     = pc_data_q;
        retired_d     = retired_q;
        halted_d      = halted_q;
        err_d         = err_q;
        mem_req       = 1'b0;
        mem_addr      = 8'h00;
        pc_step       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    wait_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_in;
                if (mem_ack) begin
                    instr_d       = mem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d    = 1'b1;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (instr_q == HALT_OP) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (instr_q[7:6] == 2'b10) begin
                    wait_d  = '0;
                    state_d = S_OPERAND;
                end else begin
                    state_d = S_UPDATE;
                    unique case (instr_q[7:6])
                        2'b00:   pc_m_d = 2'b00;
                        2'b01:   pc_m_d = 2'b01;
                        default: pc_m_d = taken ? 2'b11 : 2'b00;
                    endcase
                end
            end
            S_OPERAND: begin
                mem_req  = 1'b1;
                mem_addr = pc_plus1;
                if (mem_ack) begin
                    pc_m_d    = 2'b10;
                    pc_data_d = taken ? mem_rdata : pc_plus2;
                    state_d   = S_UPDATE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d    = 1'b1;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_UPDATE: begin
                pc_step = 1'b1;
                if (retired_q != {CNT_W{1'b1}}) begin
                    retired_d = retired_q + CNT_W'(1);
                end
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (run) begin
                    wait_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign pc_m        = pc_m_q;
    assign pc_data     = pc_data_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign retired     = retired_q;
    assign halted      = halted_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a ROM responder with programmable ack
// latency, and a scoreboard of expected fetch addresses, opcodes and PC steps.
module tb_pc_fetch_ctrl;

    typedef struct packed {
        logic [1:0] m;
        logic [7:0] d;
        logic       chk;
    } stepExp_t;

    logic        clk;
    logic        clr;
    logic        run;
    logic [7:0]  pc_in;
    logic [7:0]  alu_res;
    logic        alu_zero;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [1:0]  pc_m;
    logic [7:0]  pc_data;
    logic        pc_step;
    logic [7:0]  instr;
    logic        instr_valid;
    logic [15:0] retired;
    logic        halted;
    logic        err;

    logic [7:0]  rom [256];
    int          ackDelay;
    int          reqCnt;
    int          testsRun;
    int          failCount;
    logic [15:0] expRetired;

    logic [7:0]  addrQ [$];
    logic [7:0]  instrQ [$];
    stepExp_t    stepQ [$];

    logic [7:0]  expA;
    logic [7:0]  expI;
    stepExp_t    expS;

    pc_fetch_ctrl #(
        .TIMEOUT(15),
        .CNT_W  (16),
        .HALT_OP(8'hFF)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .run        (run),
        .pc_in      (pc_in),
        .alu_res    (alu_res),
        .alu_zero   (alu_zero),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pc_m       (pc_m),
        .pc_data    (pc_data),
        .pc_step    (pc_step),
        .instr      (instr),
        .instr_valid(instr_valid),
        .retired    (retired),
        .halted     (halted),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM responder: acks in the (ackDelay+1)-th cycle of a continuous request.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        reqCnt    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (reqCnt == ackDelay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rom[mem_addr];
                    reqCnt    = 0;
                end else begin
                    mem_ack = 1'b0;
                    reqCnt++;
                end
            end else begin
                mem_ack = 1'b0;
                reqCnt  = 0;
            end
        end
    end

    // Scoreboard: every acked fetch, decoded opcode and PC step is matched in order.
    always @(negedge clk) begin
        if (!clr) begin
            if (mem_req && mem_ack) begin
                testsRun++;
                if (addrQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL fetch_addr: unexpected fetch at %02h", mem_addr);
                end else begin
                    expA = addrQ.pop_front();
                    if (mem_addr !== expA) begin
                        failCount++;
                        $display("[TB] FAIL fetch_addr: got %02h expected %02h", mem_addr, expA);
                    end
                end
            end
            if (instr_valid) begin
                testsRun++;
                if (instrQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL instr: unexpected instr_valid with %02h", instr);
                end else begin
                    expI = instrQ.pop_front();
                    if (instr !== expI) begin
                        failCount++;
                        $display("[TB] FAIL instr: got %02h expected %02h", instr, expI);
                    end
                end
            end
            if (pc_step) begin
                testsRun++;
                if (stepQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL pc_step: unexpected step pc_m=%b pc_data=%02h", pc_m, pc_data);
                end else begin
                    expS = stepQ.pop_front();
                    if (pc_m !== expS.m || (expS.chk && pc_data !== expS.d)) begin
                        failCount++;
                        $display("[TB] FAIL pc_step: got pc_m=%b pc_data=%02h expected pc_m=%b pc_data=%02h",
                                 pc_m, pc_data, expS.m, expS.d);
                    end
                end
            end
        end
    end

    task automatic expectInstr(input logic [7:0] addr, input logic [7:0] op, input logic twoByte,
                               input logic [1:0] m, input logic [7:0] d, input logic chk);
        addrQ.push_back(addr);
        if (twoByte) addrQ.push_back(addr + 8'd1);
        instrQ.push_back(op);
        stepQ.push_back({m, d, chk});
        expRetired = expRetired + 16'd1;
    endtask

    task automatic startOne();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 100; c++) begin
            if (addrQ.size() == 0 && instrQ.size() == 0 && stepQ.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulseClear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        expRetired = 16'd0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++;
        if ({mem_req, mem_addr, pc_m, pc_data, pc_step, instr, instr_valid, retired, halted, err} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: req=%b addr=%02h m=%b data=%02h step=%b instr=%02h ret=%0d halted=%b err=%b, all must be 0",
                     mem_req, mem_addr, pc_m, pc_data, pc_step, instr, retired, halted, err);
        end
        clr = 1'b0;
        expRetired = 16'd0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int firstStep;
        int refetch;
        int steps;
        bit prevReq;
        logic [15:0] base;
        base = expRetired;
        pc_in = 8'h00;
        rom[8'h00] = 8'h00;
        ackDelay = 1;
        alu_zero = 1'b0;
        repeat (2) expectInstr(8'h00, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0);
        firstStep = -1;
        refetch = -1;
        steps = 0;
        prevReq = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 80 && steps < 2; c++) begin
            @(negedge clk);
            if (mem_req && !prevReq && firstStep >= 0 && refetch < 0) refetch = c;
            prevReq = mem_req;
            if (pc_step) begin
                steps++;
                if (firstStep < 0) firstStep = c;
            end
            if (firstStep >= 0 && c == firstStep + 1) begin
                testsRun++;
                if (retired !== base + 16'd1) begin
                    failCount++;
                    $display("[TB] FAIL retired_first: got %0d expected %0d", retired, base + 16'd1);
                end
            end
        end
        run = 1'b0;
        drain();
        testsRun++;
        if (refetch - firstStep != 2) begin
            failCount++;
            $display("[TB] FAIL refetch_gap: got %0d cycles expected 2", refetch - firstStep);
        end
        testsRun++;
        if (retired !== expRetired || addrQ.size() + instrQ.size() + stepQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL back_to_back: retired=%0d expected %0d, pending=%0d",
                     retired, expRetired, addrQ.size() + instrQ.size() + stepQ.size());
        end
    endtask

    task automatic test_single_byte_classes();
        logic [7:0] tAddr [5] = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h32};
        logic [7:0] tOp   [5] = '{8'hE0, 8'hE0, 8'h40, 8'hC0, 8'h60};
        logic       tZero [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0] tM    [5] = '{2'b00, 2'b11, 2'b01, 2'b11, 2'b01};
        for (int i = 0; i < 5; i++) begin
            pc_in = tAddr[i];
            rom[tAddr[i]] = tOp[i];
            alu_zero = tZero[i];
            expectInstr(tAddr[i], tOp[i], 1'b0, tM[i], 8'h00, 1'b0);
            startOne();
            drain();
        end
        testsRun++;
        if (retired !== expRetired || addrQ.size() + instrQ.size() + stepQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL single_byte: retired=%0d expected %0d, pending=%0d",
                     retired, expRetired, addrQ.size() + instrQ.size() + stepQ.size());
        end
    endtask

    task automatic test_jump();
        pc_in = 8'h05;
        rom[8'h05] = 8'h80;
        rom[8'h06] = 8'h3C;
        alu_zero = 1'b0;
        expectInstr(8'h05, 8'h80, 1'b1, 2'b10, 8'h3C, 1'b1);
        startOne();
        drain();
        pc_in = 8'h10;
        rom[8'h10] = 8'hA0;
        rom[8'h11] = 8'h44;
        alu_zero = 1'b0;
        expectInstr(8'h10, 8'hA0, 1'b1, 2'b10, 8'h12, 1'b1);
        startOne();
        drain();
        alu_zero = 1'b1;
        expectInstr(8'h10, 8'hA0, 1'b1, 2'b10, 8'h44, 1'b1);
        startOne();
        drain();
        testsRun++;
        if (addrQ.size() + instrQ.size() + stepQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL jump_drain: %0d expectations left", addrQ.size() + instrQ.size() + stepQ.size());
        end
    endtask

    task automatic test_wrap_and_hold();
        pc_in = 8'hFF;
        rom[8'hFF] = 8'h80;
        rom[8'h00] = 8'h5A;
        alu_zero = 1'b0;
        expectInstr(8'hFF, 8'h80, 1'b1, 2'b10, 8'h5A, 1'b1);
        startOne();
        drain();
        rom[8'hFF] = 8'hA0;
        expectInstr(8'hFF, 8'hA0, 1'b1, 2'b10, 8'h01, 1'b1);
        startOne();
        drain();
        pc_in = 8'h22;
        rom[8'h22] = 8'h00;
        expectInstr(8'h22, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0);
        startOne();
        drain();
        testsRun++;
        if (pc_data !== 8'h01 || pc_m !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL hold_pc_data: got pc_m=%b pc_data=%02h expected pc_m=00 pc_data=01", pc_m, pc_data);
        end
    endtask

    task automatic test_ack_on_timeout_cycle();
        pc_in = 8'h40;
        rom[8'h40] = 8'h00;
        ackDelay = 14;
        expectInstr(8'h40, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0);
        startOne();
        drain();
        ackDelay = 1;
        testsRun++;
        if (err !== 1'b0 || halted !== 1'b0 || retired !== expRetired) begin
            failCount++;
            $display("[TB] FAIL late_ack: err=%b halted=%b retired=%0d expected 0 0 %0d", err, halted, retired, expRetired);
        end
    endtask

    task automatic test_run_drop_operand();
        bit seen;
        pc_in = 8'h05;
        alu_zero = 1'b0;
        ackDelay = 2;
        expectInstr(8'h05, 8'h80, 1'b1, 2'b10, 8'h3C, 1'b1);
        seen = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 8'h06) seen = 1'b1;
        end
        run = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        ackDelay = 1;
        testsRun++;
        if (!seen || mem_req !== 1'b0 || retired !== expRetired || stepQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL run_drop_operand: operand_seen=%b req=%b retired=%0d expected 1 0 %0d",
                     seen, mem_req, retired, expRetired);
        end
    endtask

    task automatic test_clr_mid_fetch();
        logic wasReq;
        pc_in = 8'h33;
        ackDelay = 15;
        run = 1'b1;
        repeat (3) @(negedge clk);
        run = 1'b0;
        wasReq = mem_req;
        #2 clr = 1'b1;
        #1;
        testsRun++;
        if (wasReq !== 1'b1 ||
            {mem_req, mem_addr, pc_m, pc_data, pc_step, instr, instr_valid, retired, halted, err} !== '0) begin
            failCount++;
            $display("[TB] FAIL clr_async: was_req=%b req=%b m=%b data=%02h instr=%02h ret=%0d, expected 1 then all 0",
                     wasReq, mem_req, pc_m, pc_data, instr, retired);
        end
        @(negedge clk);
        clr = 1'b0;
        expRetired = 16'd0;
        ackDelay = 1;
        @(negedge clk);
    endtask

    task automatic test_halt_op();
        int reqSeen;
        pc_in = 8'h70;
        rom[8'h70] = 8'h00;
        expectInstr(8'h70, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0);
        startOne();
        drain();
        pc_in = 8'h50;
        rom[8'h50] = 8'hFF;
        addrQ.push_back(8'h50);
        instrQ.push_back(8'hFF);
        startOne();
        drain();
        reqSeen = 0;
        run = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_req) reqSeen++;
        end
        run = 1'b0;
        testsRun++;
        if (halted !== 1'b1 || err !== 1'b0 || retired !== expRetired || reqSeen != 0) begin
            failCount++;
            $display("[TB] FAIL halt_op: halted=%b err=%b retired=%0d req_cycles=%0d expected 1 0 %0d 0",
                     halted, err, retired, reqSeen, expRetired);
        end
        pulseClear();
    endtask

    task automatic test_timeout();
        int reqSeen;
        pc_in = 8'h60;
        ackDelay = 15;
        reqSeen = 0;
        run = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            run = 1'b0;
            if (mem_req) reqSeen++;
        end
        testsRun++;
        if (reqSeen != 15 || err !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0 || retired !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL timeout: req_cycles=%0d err=%b halted=%b req=%b retired=%0d expected 15 1 1 0 0",
                     reqSeen, err, halted, mem_req, retired);
        end
        ackDelay = 1;
        pulseClear();
    endtask

    initial begin
        #500000;
        failCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        testsRun   = 0;
        failCount  = 0;
        expRetired = 16'd0;
        ackDelay   = 1;
        clr        = 1'b1;
        run        = 1'b0;
        pc_in      = 8'h00;
        alu_res    = 8'h9C;
        alu_zero   = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;

        test_reset();
        test_back_to_back();
        test_single_byte_classes();
        test_jump();
        test_wrap_and_hold();
        test_ack_on_timeout_cycle();
        test_run_drop_operand();
        test_clr_mid_fetch();
        test_halt_op();
        test_timeout();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch and sequencing controller that drives the program-counter unit of the calculator datapath.
- Reads the current PC and fetches the instruction byte at that address over a req/ack memory handshake.
- Decodes the instruction class and issues the PC mode select (M), the load data and a single-cycle step strobe.
- Sits between the program ROM, the PC unit and the ALU result bus.

Parameters:
TIMEOUT, 15, cycles without mem_ack before a fetch aborts with error (1..255)
CNT_W, 16, width of retired-instruction counter
HALT_OP, 8'hFF, opcode that stops the sequencer

Ports:
clk  input  1  system clock, all state on rising edge
clr  input  1  asynchronous active-high reset
run  input  1  level; 1 = execute instructions, 0 = stop after current instruction
pc_in  input  8  current PC value from PC unit
alu_res  input  8  ALU result (jump target for class 11)
alu_zero  input  1  ALU zero flag (condition for conditional jumps)
mem_addr  output  8  fetch address
mem_req  output  1  fetch request
mem_ack  input  1  memory acknowledge, rdata valid same cycle
mem_rdata  input  8  fetched byte
pc_m  output  2  PC mode: 00 inc, 01 dec, 10 load pc_data, 11 load ALU result
pc_data  output  8  load value for mode 10
pc_step  output  1  one-cycle strobe: PC unit applies pc_m
instr  output  8  last decoded instruction
instr_valid  output  1  one-cycle pulse when instr updates
retired  output  CNT_W  count of completed instructions
halted  output  1  sticky, set by HALT_OP or timeout
err  output  1  sticky fetch-timeout flag

Behaviour:
Reset (clr=1, asynchronous):
- state=IDLE.
- All outputs 0: pc_m=00, pc_data=00, retired=0, halted=0, err=0, mem_req=0.
- clr mid-handshake drops mem_req immediately.

Instruction format:
- [7:6] class; [5] cond (1 = act only if alu_zero=1).
- Class 10 is two bytes: the second byte is the absolute target.
- HALT_OP takes precedence over class decode.

States:
- IDLE: wait for run=1 -> FETCH.
- FETCH:
  - mem_req=1, mem_addr=pc_in.
  - On mem_ack: latch mem_rdata into instr, pulse instr_valid, drop req next cycle -> DECODE.
- DECODE:
  - HALT_OP -> HALT.
  - Class 10 -> OPERAND.
  - Otherwise -> UPDATE.
- OPERAND:
  - mem_req=1, mem_addr=pc_in+1 (8-bit wrap, FF->00).
  - On ack: latch target -> UPDATE.
- UPDATE (exactly one cycle), pc_step=1:
  - Class 00: pc_m=00.
  - Class 01: pc_m=01.
  - Class 10 taken: pc_m=10, pc_data=target. Not taken: pc_m=10, pc_data=pc_in+2 (wrap).
  - Class 11 taken: pc_m=11. Not taken: pc_m=00.
  - Unconditional (bit5=0) is always taken.
  - retired increments; it saturates at all-ones.
  - -> SETTLE.
- SETTLE: one cycle, pc_step=0, allows the PC unit to update pc_in.
  - run=1 -> FETCH; run=0 -> IDLE.
- HALT: halted=1, mem_req=0, pc_step=0. Exit only via clr.

Timeout:
- A wait counter is cleared on entry to FETCH/OPERAND and increments each cycle mem_req=1 with mem_ack=0.
- On reaching TIMEOUT: err=1, halted=1, req drops -> HALT.
- If mem_ack coincides with the timeout cycle, ack wins and no error is raised.

Holding rules:
- pc_m/pc_data are registered and hold their value until the next UPDATE.
- run falling mid-instruction has no effect until SETTLE.
- mem_ack outside FETCH/OPERAND is ignored.

Test Plan:
- Reset, run=1, pc_in=00, ROM[00]=8'h00 with ack 1 cycle after req -> mem_addr=00, instr=00, one pc_step with pc_m=00, retired=1, FETCH re-entered two cycles after pc_step.
- ROM[05]=8'h80, ROM[06]=8'h3C -> second fetch at addr 06, pc_step with pc_m=10, pc_data=3C.
- ROM[10]=8'hA0 (cond), ROM[11]=8'h44, alu_zero=0 -> pc_m=10, pc_data=12. Same ROM contents with alu_zero=1 -> pc_data=44.
- ROM[FF]=8'h80 at pc_in=FF -> operand fetched from addr 00 (wrap). ROM[20]=8'hE0, alu_zero=0 -> pc_m=00.
- mem_ack held 0 for 15 cycles -> err=1, halted=1, mem_req=0, no pc_step. Ack arriving on cycle 15 -> no error.
- ROM byte FF -> halted=1, no pc_step, retired unchanged. Assert clr mid-FETCH -> outputs 0 asynchronously; run=0 during OPERAND -> instruction completes, then IDLE.
